bin_search_ctrl: RTL
====================

# bin_search_ctrl

Sequential binary-search controller that consumes the gt/eq/lt result of a magnitude comparator. It drives the comparator's `b` operand with a probe value and reads back the relation of an unknown target (on the comparator's `a` operand) against that probe. It converges on the target's value in at most WIDTH+1 probes. It sits beside a combinational comparator and is the result-consuming end of that compare interface.

## Interface
- `WIDTH`, default 8: operand width. Search range is 0 .. 2^WIDTH-1.
- `clk`  in  1: single clock. All state changes on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: request a new search. Sampled only in IDLE.
- `gt`  in  1: comparator result, target > guess.
- `eq`  in  1: comparator result, target == guess.
- `lt`  in  1: comparator result, target < guess.
- `guess`  out  WIDTH: probe value, driven to the comparator `b` input.
- `busy`  out  1: high in PROBE.
- `done`  out  1: one-cycle pulse, high in DONE.
- `found`  out  1: valid with `done`; 1 = target located.
- `result`  out  WIDTH: located value. Held until the next `start` is accepted.
- `probes`  out  $clog2(WIDTH+2): number of probes taken in the last or current search.
- `err`  out  1: comparator protocol error (see Configuration). Sticky until the next accepted `start` or `rst`.

## Operation
- Registers: `lo`, `hi` (WIDTH+1 bits each, to absorb under/overflow), state, `result`, `found`, `probes`, `err`.
- `guess` = (`lo` + `hi`) >> 1, computed at WIDTH+1 bits and truncated to WIDTH. It is decoded from registers only; there is no combinational path from any input to `guess`.
- FSM: IDLE -> PROBE -> DONE -> IDLE.
  - **IDLE:** when `start`=1, load `lo`=0, `hi`=2^WIDTH-1, `probes`=0, `found`=0, `err`=0, then go to PROBE.
  - **PROBE:** gt/eq/lt are sampled each cycle and `probes` increments.
    - `eq`: `result`=`guess`, `found`=1, go to DONE.
    - `gt`: `lo`=`guess`+1.
    - `lt`: `hi`=`guess`-1, computed as a signed WIDTH+1-bit value so that 0-1 gives -1.
    - If the updated `lo` > `hi`: `found`=0, `result` unchanged (0 after start), go to DONE.
  - **DONE:** `done`=1 for one cycle, then go to IDLE.
- Priority when several result inputs are high: `eq` > `gt` > `lt`. If none is high, the probe is wasted: `lo`/`hi` are unchanged and `probes` still increments. If `probes` reaches WIDTH+1 without `eq`, go to DONE with `found`=0.
- `start` while busy or in DONE is ignored.
- `rst` mid-search: immediate return to IDLE. The partial search is discarded.
- Reset values: state=IDLE, `busy`=0, `done`=0, `found`=0, `result`=0, `probes`=0, `err`=0, `lo`=0, `hi`=2^WIDTH-1, so `guess` = 2^(WIDTH-1)-1.

## Timing
- `start` accepted at edge N. PROBE occupies cycles N+1 .. N+k, where k = number of probes (1 ≤ k ≤ WIDTH+1). `done` is high in cycle N+k+1.
- The comparator must settle gt/eq/lt within the same cycle that `guess` is presented. The inputs are sampled at the end of each PROBE cycle.
- Minimum turnaround: a new `start` can be accepted in the IDLE cycle right after DONE. Back-to-back searches therefore cost k+2 cycles each.

## Configuration
- `BIN_SEARCH_ONEHOT_CHECK_EN`
  - **Defined:** in every PROBE cycle, a gt/eq/lt pattern that is not exactly one-hot sets `err`. The search still proceeds under the priority rules above.
  - **Undefined:** the checking logic is omitted and `err` is tied to 0.
  - Search behaviour is otherwise identical in both builds.

## Test plan
- WIDTH=8, ideal comparator, target=127, `start` at edge 0 -> one probe (`guess`=127), `done` in cycle 2, `found`=1, `result`=127, `probes`=1.
- Target=0 -> guesses 127,63,31,15,7,3,1,0; `found`=1, `result`=0, `probes`=8, `done` in cycle 9.
- Target=255 -> guesses 127,191,223,239,247,251,253,254,255; `found`=1, `probes`=9, `done` in cycle 10.
- Comparator stuck at `lt`=1 -> guesses 127..0 as in the target=0 case, then `hi` underflows; `found`=0, `result`=0, `probes`=8.
- With the macro defined, force gt=lt=1 on probe 2 -> `err`=1 and held; search continues with `gt` priority. With the macro undefined, `err` stays 0.
- Assert `rst` in the 4th PROBE cycle of a target=0 search -> next cycle state is IDLE with all reset values. A `start` asserted while `busy`=1 has no effect.

Source files
------------

// File: rtl/bin_search_if.sv
// Compare-port bundle between the binary-search controller and a magnitude comparator.
// master = controller side (drives the probe value, consumes gt/eq/lt); slave = comparator/host side.
interface bin_search_if #(
    parameter int WIDTH = 8
);
    localparam int PW = $clog2(WIDTH + 2);

    logic             start;
    logic             gt;
    logic             eq;
    logic             lt;
    logic [WIDTH-1:0] guess;
    logic             busy;
    logic             done;
    logic             found;
    logic [WIDTH-1:0] result;
    logic [PW-1:0]    probes;
    logic             err;

    modport master (
        input  start, gt, eq, lt,
        output guess, busy, done, found, result, probes, err
    );

    modport slave (
        output start, gt, eq, lt,
        input  guess, busy, done, found, result, probes, err
    );
endinterface

// File: rtl/bin_search_ctrl.sv
// Binary-search controller: probes a comparator with guess=(lo+hi)/2 and converges in <= WIDTH+1 probes.
// Optional BIN_SEARCH_ONEHOT_CHECK_EN flags non-one-hot gt/eq/lt patterns on err; otherwise err is tied low.
module bin_search_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    bin_search_if.master bus
);
    localparam int PW = $clog2(WIDTH + 2);
    localparam logic [WIDTH:0]  HI_INIT   = {1'b0, {WIDTH{1'b1}}};
    localparam logic [WIDTH:0]  ONE_W     = (WIDTH+1)'(1);
    localparam logic [PW-1:0]   ONE_P     = PW'(1);
    localparam logic [PW-1:0]   PROBE_MAX = PW'(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PROBE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH:0]   lo_q, lo_d;
    logic [WIDTH:0]   hi_q, hi_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             found_q, found_d;
    logic [PW-1:0]    probes_q, probes_d;
    logic [WIDTH-1:0] guess;
`ifdef BIN_SEARCH_ONEHOT_CHECK_EN
    logic             err_q, err_d;
`endif

    // Registers only feed the probe value; the comparator result never loops back combinationally.
    assign guess = WIDTH'((lo_q + hi_q) >> 1);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            lo_q     <= '0;
            hi_q     <= HI_INIT;
            result_q <= '0;
            found_q  <= 1'b0;
            probes_q <= '0;
`ifdef BIN_SEARCH_ONEHOT_CHECK_EN
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            result_q <= result_d;
            found_q  <= found_d;
            probes_q <= probes_d;
`ifdef BIN_SEARCH_ONEHOT_CHECK_EN
            err_q    <= err_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        result_d = result_q;
        found_d  = found_q;
        probes_d = probes_q;
`ifdef BIN_SEARCH_ONEHOT_CHECK_EN
        err_d    = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    lo_d     = '0;
                    hi_d     = HI_INIT;
                    probes_d = '0;
                    found_d  = 1'b0;
                    result_d = '0;
`ifdef BIN_SEARCH_ONEHOT_CHECK_EN
                    err_d    = 1'b0;
`endif
                    state_d  = S_PROBE;
                end
            end
            S_PROBE: begin
                probes_d = probes_q + ONE_P;
`ifdef BIN_SEARCH_ONEHOT_CHECK_EN
                if (!$onehot({bus.gt, bus.eq, bus.lt})) begin
                    err_d = 1'b1;
                end
`endif
                if (bus.eq) begin
                    result_d = guess;
                    found_d  = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    if (bus.gt) begin
                        lo_d = {1'b0, guess} + ONE_W;
                    end else if (bus.lt) begin
                        hi_d = {1'b0, guess} - ONE_W;
                    end
                    // hi never exceeds 2^WIDTH-1, so a set MSB can only mean it went to -1.
                    if (hi_d[WIDTH] || (lo_d > hi_d) || (probes_d == PROBE_MAX)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.guess  = guess;
    assign bus.busy   = (state_q == S_PROBE);
    assign bus.done   = (state_q == S_DONE);
    assign bus.found  = found_q;
    assign bus.result = result_q;
    assign bus.probes = probes_q;
`ifdef BIN_SEARCH_ONEHOT_CHECK_EN
    assign bus.err    = err_q;
`else
    assign bus.err    = 1'b0;
`endif
endmodule
